// File: rtl/ide_cycle_sequencer.sv
// ============================================================================
//  Module      : ide_cycle_sequencer
//  Description : Runs each CPU bus cycle that hits the IDE board window.
//                The address is decoded into ATA task-file selects (CS0/CS1,
//                DA) or the boot ROM half. The module times the IOR/IOW
//                strobes and ROM_OE_n, then raises dtack to the bus glue.
//                Optional IORDY wait-state support is enabled by defining
//                the macro IDE_IORDY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ide_cycle_sequencer #(
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned STROBE_CYC    = 2,
  parameter int unsigned ROM_CYC       = 2,
  parameter int unsigned IORDY_TIMEOUT = 32
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic [23:1] ADDR,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic        ide_access,
  input  logic        IORDY,
  output logic        IDE_CS0_n,
  output logic        IDE_CS1_n,
  output logic [2:0]  IDE_DA,
  output logic        IDE_IOR_n,
  output logic        IDE_IOW_n,
  output logic        ROM_OE_n,
  output logic        dtack,
  output logic        busy
);

  localparam logic [3:0] C_SETUP_N  = 4'(SETUP_CYC);
  localparam logic [3:0] C_STROBE_N = 4'(STROBE_CYC);
  localparam logic [3:0] C_ROM_N    = 4'(ROM_CYC);
  localparam logic [5:0] C_TMO_N    = 6'(IORDY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_ROMRD  = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rom_q, rom_d;     // cycle targets the ROM half
  logic        rw_q, rw_d;       // cycle direction captured at start
  logic        cs1_q, cs1_d;     // CS1 (rather than CS0) selected
  logic [2:0]  da_q, da_d;
  logic [5:0]  tmo_q, tmo_d;     // remaining IORDY wait budget

  logic        start;
  logic        cnt_exp;
  logic [3:0]  cnt_dec;
  logic        iordy_s;

  // A write may only start once a data strobe shows the data is valid.
  assign start   = ide_access & ~AS_n & (RW | ~UDS_n | ~LDS_n);
  assign cnt_exp = (cnt_q <= 4'd1);
  assign cnt_dec = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;

`ifdef IDE_IORDY_EN
  logic [1:0] iordy_sync_q;

  // Two-flop synchroniser for the drive's asynchronous IORDY.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) iordy_sync_q <= 2'b11;
    else          iordy_sync_q <= {iordy_sync_q[0], IORDY};
  end

  assign iordy_s = iordy_sync_q[1];

  logic unused_ok;
  assign unused_ok = ^{ADDR[23:16], ADDR[8:1]};
`else
  assign iordy_s = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{ADDR[23:16], ADDR[8:1], IORDY, C_TMO_N};
`endif

  // State and captured decode registers; async reset drops every strobe at once.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rom_q   <= 1'b0;
      rw_q    <= 1'b0;
      cs1_q   <= 1'b0;
      da_q    <= 3'd0;
      tmo_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rom_q   <= rom_d;
      rw_q    <= rw_d;
      cs1_q   <= cs1_d;
      da_q    <= da_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic; counters count down and stick at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rom_d   = rom_q;
    rw_d    = rw_q;
    cs1_d   = cs1_q;
    da_d    = da_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rw_d  = RW;
          rom_d = ADDR[15];
          if (ADDR[15]) begin
            if (RW) begin
              state_d = S_ROMRD;
              cnt_d   = C_ROM_N;
            end else begin
              state_d = S_ACK;   // ROM is read-only: acknowledge and ignore
            end
          end else begin
            cs1_d   = ADDR[12];
            da_d    = ADDR[11:9];
            state_d = S_SETUP;
            cnt_d   = C_SETUP_N;
          end
        end
      end
      S_SETUP: begin
        if (AS_n) begin
          state_d = S_IDLE;
        end else if (cnt_exp) begin
          state_d = S_STROBE;
          cnt_d   = C_STROBE_N;
          tmo_d   = C_TMO_N;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_STROBE: begin
        if (AS_n) begin
          state_d = S_IDLE;
        end else if (cnt_exp) begin
          if (!iordy_s && (tmo_q != 6'd0)) tmo_d = tmo_q - 6'd1;
          else                             state_d = S_ACK;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_ROMRD: begin
        if (AS_n)         state_d = S_IDLE;
        else if (cnt_exp) state_d = S_ACK;
        else              cnt_d   = cnt_dec;
      end
      S_ACK: begin
        if (AS_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic ide_sel;
  assign ide_sel   = ~rom_q & ((state_q == S_SETUP) | (state_q == S_STROBE) | (state_q == S_ACK));
  assign IDE_CS0_n = ~(ide_sel & ~cs1_q);
  assign IDE_CS1_n = ~(ide_sel &  cs1_q);
  assign IDE_DA    = da_q;
  assign IDE_IOR_n = ~((state_q == S_STROBE) &  rw_q);
  assign IDE_IOW_n = ~((state_q == S_STROBE) & ~rw_q);
  assign ROM_OE_n  = ~(rom_q & rw_q & ((state_q == S_ROMRD) | (state_q == S_ACK)));
  assign dtack     = (state_q == S_ACK);
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
